uart_matrix_loader: RTL and testbench
=====================================

// Module: uart_matrix_loader
// PURPOSE
//  Loads NUM_MAT matrices of ROWS x COLS elements (DATA_W bits each) from a UART byte stream into matrix memory.
//  Sits between the UART receiver (byte valid/error interface) and the matrix memories that feed the multiplier.
//  Per-frame matrix selection, multi-byte elements, framing/timeout abort, per-matrix loaded flags.
// PARAMETERS
//  ROWS      2          matrix rows
//  COLS      2          matrix columns
//  DATA_W    8          element width; multiple of 8; BPE = DATA_W/8 bytes per element
//  NUM_MAT   2          number of destination matrices (1..16)
//  HDR_TAG   4'hA       required upper nibble of the frame header byte
//  TIMEOUT   100000     max clk cycles between bytes inside a frame
// PORTS
//  clk           in   1          system clock
//  rst           in   1          reset, synchronous, active-low
//  load_en       in   1          arm: headers accepted only while high
//  rx_valid      in   1          one-cycle strobe, rx_byte valid
//  rx_byte       in   8          received byte
//  rx_err        in   1          framing error on the byte strobed with rx_valid
//  clear_loaded  in   NUM_MAT    one-cycle per-bit clear of loaded[]
//  wr_en         out  1          one-cycle memory write strobe
//  wr_mat        out  MAT_W      destination matrix, MAT_W = max(1,clog2(NUM_MAT))
//  wr_addr       out  ADDR_W     row-major element index, ADDR_W = max(1,clog2(ROWS*COLS))
//  wr_data       out  DATA_W     element value
//  loaded        out  NUM_MAT    sticky: matrix k fully and cleanly loaded
//  frame_done    out  1          one-cycle pulse on clean frame completion
//  frame_err     out  1          one-cycle pulse on abort (rx_err, timeout, checksum)
//  busy          out  1          high while not in IDLE
// BEHAVIOUR
//  Reset (rst==0 at posedge clk): state=IDLE; all outputs 0; element/byte counters 0; loaded=0.
//  Frame: header {HDR_TAG, mat_id[3:0]}, then ROWS*COLS*BPE payload bytes, little-endian per element.
//  FSM IDLE -> PAYLOAD -> (CHECK, CHECKSUM_EN only) -> IDLE.
//  IDLE: rx_valid & load_en & !rx_err & tag==HDR_TAG & mat_id<NUM_MAT -> latch mat_id, PAYLOAD.
//    Any other byte is dropped silently. No pulse. loaded is unchanged.
//  PAYLOAD: each rx_valid shifts the byte in at lane byte_cnt. On the BPE-th byte, wr_en=1 on the next cycle
//    with wr_addr=elem_cnt and wr_data=assembled value. Write latency is 1 cycle after the last byte's rx_valid.
//  rx_valid may strobe on consecutive cycles; no bytes are lost. wr_mat/wr_addr/wr_data hold their value between writes.
//  Last element written -> loaded[mat]<=1, frame_done pulse (same cycle as wr_en), return to IDLE.
//  Abort: rx_err with rx_valid, or TIMEOUT cycles without rx_valid in PAYLOAD.
//    -> frame_err pulse next cycle, IDLE, counters 0, loaded[mat] cleared.
//    Writes already issued are not undone.
//  load_en falling mid-frame does not abort; the frame completes.
//  clear_loaded[k] coincident with loaded[k] set: the set wins.
//  Reset mid-frame: immediate return to reset state; no partial write is emitted.
//  A new header is accepted the cycle after return to IDLE (back-to-back frames allowed).
// CONFIGURATION
//  UART_LOADER_CHECKSUM_EN defined:
//    one extra byte after the payload = XOR of all payload bytes; state CHECK waits for it.
//    Match: loaded set, frame_done.
//    Mismatch: frame_err, loaded[mat] cleared.
//    Writes are still issued during PAYLOAD. TIMEOUT also applies in CHECK.
//  Undefined: no trailer byte; completion on the last element as above.
// STRUCTURE
//  Package uart_ld_pkg: state enum (IDLE, PAYLOAD, CHECK), HDR_TAG default, clog2-based width helpers.
//  Sub-module uart_byte_packer: byte lane counter + DATA_W shift/assemble register;
//    outputs elem_valid/elem_data; clears on abort.
//  Top: FSM, element counter, timeout counter, loaded register, checksum accumulator.
// TESTING
//  Defaults, load_en=1, bytes A0 11 22 33 44:
//    4 wr_en with mat 0, addr 0..3, data 11,22,33,44; frame_done with the last write; loaded=01.
//  DATA_W=16, header A1, bytes 34 12 78 56 ...:
//    wr_mat=1, addr0 data 16'h1234, addr1 data 16'h5678; loaded[1]=1.
//  Header A7 (mat_id>=NUM_MAT), 55 (bad tag), A0 with load_en=0:
//    no wr_en, no pulses, state stays IDLE.
//  A0 11 22 then rx_err on the next byte: frame_err, 2 writes only, loaded[0]=0, busy=0.
//    A following clean frame succeeds.
//  A0 11 then silence for TIMEOUT cycles: frame_err at cycle TIMEOUT; rst=0 mid-frame clears all outputs.
//  CHECKSUM_EN: A0 11 22 33 44 44 -> frame_done; trailer 00 -> frame_err, loaded[0]=0.

Source files
------------

// File: rtl/uart_ld_pkg.sv
// Shared types and width helpers for the UART matrix loader.
package uart_ld_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PAYLOAD = 2'd1,
    CHECK   = 2'd2
  } state_t;

  localparam logic [3:0] HDR_TAG_DEF = 4'hA;

  // max(1, clog2(n)) so single-entry ranges still get a 1-bit field
  function automatic int width_of(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/uart_byte_packer.sv
// Collects little-endian bytes into DATA_W-bit elements.
// elem_valid/elem_data are combinational on the byte that completes an element,
// so the parent can register the write one cycle after that byte's strobe.
module uart_byte_packer
  import uart_ld_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              byte_valid,
  input  logic [7:0]        byte_in,
  output logic              elem_valid,
  output logic [DATA_W-1:0] elem_data
);

  localparam int BPE   = DATA_W / 8;
  localparam int CNT_W = width_of(BPE);

  logic [CNT_W-1:0]  byte_cnt;
  logic [DATA_W-1:0] acc;
  logic              last_lane;

  assign last_lane  = (byte_cnt == CNT_W'(BPE - 1));
  assign elem_valid = byte_valid & last_lane;

  // Current byte overlays its lane so the final byte needs no extra cycle
  always_comb begin
    elem_data = acc;
    for (int k = 0; k < BPE; k++)
      if (CNT_W'(k) == byte_cnt) elem_data[8*k +: 8] = byte_in;
  end

  // Lane counter; cleared by reset, abort or while the loader is idle
  always_ff @(posedge clk) begin
    if (!rst || clr)
      byte_cnt <= '0;
    else if (byte_valid)
      byte_cnt <= last_lane ? '0 : byte_cnt + 1'b1;
  end

  // Assembly register; every lane is rewritten before it is consumed
  always_ff @(posedge clk) begin
    if (byte_valid)
      for (int k = 0; k < BPE; k++)
        if (CNT_W'(k) == byte_cnt) acc[8*k +: 8] <= byte_in;
  end

endmodule

// File: rtl/uart_matrix_loader.sv
// UART byte stream to matrix memory loader.
// Frame: header {HDR_TAG, mat_id}, ROWS*COLS*BPE payload bytes (little-endian per element).
// Optional feature macro UART_LOADER_CHECKSUM_EN adds an XOR trailer byte checked in CHECK.
module uart_matrix_loader
  import uart_ld_pkg::*;
#(
  parameter int         ROWS    = 2,
  parameter int         COLS    = 2,
  parameter int         DATA_W  = 8,
  parameter int         NUM_MAT = 2,
  parameter logic [3:0] HDR_TAG = HDR_TAG_DEF,
  parameter int         TIMEOUT = 100000,
  localparam int        MAT_W   = width_of(NUM_MAT),
  localparam int        ADDR_W  = width_of(ROWS * COLS)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load_en,
  input  logic               rx_valid,
  input  logic [7:0]         rx_byte,
  input  logic               rx_err,
  input  logic [NUM_MAT-1:0] clear_loaded,
  output logic               wr_en,
  output logic [MAT_W-1:0]   wr_mat,
  output logic [ADDR_W-1:0]  wr_addr,
  output logic [DATA_W-1:0]  wr_data,
  output logic [NUM_MAT-1:0] loaded,
  output logic               frame_done,
  output logic               frame_err,
  output logic               busy
);

  localparam int NELEM = ROWS * COLS;
  localparam int TMO_W = width_of(TIMEOUT + 1);

  state_t             state;
  logic [MAT_W-1:0]   mat;
  logic [ADDR_W-1:0]  elem_cnt;
  logic [TMO_W-1:0]   tmo_cnt;
`ifdef UART_LOADER_CHECKSUM_EN
  logic [7:0]         csum;
`endif

  logic              hdr_ok, in_frame, abort, pk_valid, pk_clr, last_elem;
  logic              elem_valid;
  logic [DATA_W-1:0] elem_data;

  assign hdr_ok    = rx_valid & load_en & ~rx_err & (rx_byte[7:4] == HDR_TAG)
                   & (int'({4'd0, rx_byte[3:0]}) < NUM_MAT);
  assign in_frame  = (state != IDLE);
  assign abort     = in_frame & ((rx_valid & rx_err)
                   | (~rx_valid & (tmo_cnt == TMO_W'(TIMEOUT - 1))));
  assign pk_valid  = (state == PAYLOAD) & rx_valid & ~rx_err;
  assign pk_clr    = abort | ~in_frame;
  assign last_elem = elem_valid & (elem_cnt == ADDR_W'(NELEM - 1));
  assign busy      = in_frame;

  uart_byte_packer #(.DATA_W(DATA_W)) u_packer (
    .clk        (clk),
    .rst        (rst),
    .clr        (pk_clr),
    .byte_valid (pk_valid),
    .byte_in    (rx_byte),
    .elem_valid (elem_valid),
    .elem_data  (elem_data)
  );

  // Frame FSM with registered write port, pulses, timeout and loaded flags
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      mat        <= '0;
      elem_cnt   <= '0;
      tmo_cnt    <= '0;
      loaded     <= '0;
      wr_en      <= 1'b0;
      wr_mat     <= '0;
      wr_addr    <= '0;
      wr_data    <= '0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
`ifdef UART_LOADER_CHECKSUM_EN
      csum       <= '0;
`endif
    end else begin
      wr_en      <= 1'b0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      // External clears first; a same-cycle set below overrides them
      loaded     <= loaded & ~clear_loaded;
      tmo_cnt    <= (rx_valid || !in_frame) ? '0 : tmo_cnt + 1'b1;

      if (abort) begin
        state       <= IDLE;
        elem_cnt    <= '0;
        frame_err   <= 1'b1;
        loaded[mat] <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (hdr_ok) begin
              mat      <= rx_byte[MAT_W-1:0];
              elem_cnt <= '0;
              state    <= PAYLOAD;
`ifdef UART_LOADER_CHECKSUM_EN
              csum     <= '0;
`endif
            end
          end
          PAYLOAD: begin
`ifdef UART_LOADER_CHECKSUM_EN
            if (rx_valid) csum <= csum ^ rx_byte;
`endif
            if (elem_valid) begin
              wr_en    <= 1'b1;
              wr_mat   <= mat;
              wr_addr  <= elem_cnt;
              wr_data  <= elem_data;
              elem_cnt <= elem_cnt + 1'b1;
              if (last_elem) begin
                elem_cnt <= '0;
`ifdef UART_LOADER_CHECKSUM_EN
                state    <= CHECK;
`else
                state       <= IDLE;
                frame_done  <= 1'b1;
                loaded[mat] <= 1'b1;
`endif
              end
            end
          end
`ifdef UART_LOADER_CHECKSUM_EN
          CHECK: begin
            if (rx_valid) begin
              state <= IDLE;
              if (rx_byte == csum) begin
                frame_done  <= 1'b1;
                loaded[mat] <= 1'b1;
              end else begin
                frame_err   <= 1'b1;
                loaded[mat] <= 1'b0;
              end
            end
          end
`endif
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_matrix_loader.sv
// Scoreboard bench: one byte stream drives an 8-bit and a 16-bit element loader.
module tb_uart_matrix_loader;

  localparam int NM  = 2;
  localparam int NEL = 4;
  localparam int TMO = 20;

  logic clk = 1'b0;
  logic rst, load_en, rx_valid, rx_err;
  logic [7:0] rx_byte;
  logic [1:0] clear_loaded;

  logic       a_en, a_fd, a_fe, a_bz;
  logic       a_mat;
  logic [1:0] a_addr, a_ld;
  logic [7:0] a_data;
  logic       b_en, b_fd, b_fe, b_bz;
  logic       b_mat;
  logic [1:0] b_addr, b_ld;
  logic [15:0] b_data;

  always #5 clk = ~clk;

  uart_matrix_loader #(.DATA_W(8), .NUM_MAT(NM), .TIMEOUT(TMO)) dut8 (
    .clk(clk), .rst(rst), .load_en(load_en), .rx_valid(rx_valid), .rx_byte(rx_byte),
    .rx_err(rx_err), .clear_loaded(clear_loaded), .wr_en(a_en), .wr_mat(a_mat),
    .wr_addr(a_addr), .wr_data(a_data), .loaded(a_ld), .frame_done(a_fd),
    .frame_err(a_fe), .busy(a_bz));

  uart_matrix_loader #(.DATA_W(16), .NUM_MAT(NM), .TIMEOUT(TMO)) dut16 (
    .clk(clk), .rst(rst), .load_en(load_en), .rx_valid(rx_valid), .rx_byte(rx_byte),
    .rx_err(rx_err), .clear_loaded(clear_loaded), .wr_en(b_en), .wr_mat(b_mat),
    .wr_addr(b_addr), .wr_data(b_data), .loaded(b_ld), .frame_done(b_fd),
    .frame_err(b_fe), .busy(b_bz));

  typedef struct { int d; int mat; int addr; int data; int cyc; } wr_t;
  typedef struct { int d; int kind; int cyc; } ev_t;   // kind 0 = done, 1 = err

  wr_t wq[$];
  ev_t eq[$];
  int  cyc = 0;
  int  npass = 0, ntot = 0;

  // Reference model state, one slot per loader
  bit inf[2], ck[2], exp_bz[2];
  int mat_m[2], cnt[2], acc[2], xs[2], sil[2], exp_ld[2];

  task automatic chk(input bit ok, input string name, input string detail);
    ntot++;
    if (ok) npass++;
    else $display("FAIL %s: %s", name, detail);
  endtask

  function automatic int wfind(input int d);
    foreach (wq[k]) if (wq[k].d == d) return k;
    return -1;
  endfunction

  function automatic int efind(input int d);
    foreach (eq[k]) if (eq[k].d == d) return k;
    return -1;
  endfunction

  function automatic void m_end(input int d, input int kind);
    eq.push_back('{d, kind, cyc + 1});
    if (kind == 0) exp_ld[d] |= (1 << mat_m[d]);
    else           exp_ld[d] &= ~(1 << mat_m[d]);
    inf[d] = 1'b0;
  endfunction

  // Frame-level behaviour for one input cycle; expectations land one cycle later
  function automatic void model_step(input int d, input int bpe);
    int lane;
    exp_ld[d] &= ~int'(clear_loaded);
    if (!inf[d]) begin
      if (rx_valid && load_en && !rx_err && rx_byte[7:4] == 4'hA && int'(rx_byte[3:0]) < NM) begin
        inf[d] = 1'b1; ck[d] = 1'b0; mat_m[d] = int'(rx_byte[3:0]);
        cnt[d] = 0; acc[d] = 0; xs[d] = 0; sil[d] = 0;
      end
    end else if (rx_valid && rx_err) begin
      m_end(d, 1);
    end else if (!rx_valid) begin
      sil[d]++;
      if (sil[d] == TMO) m_end(d, 1);
    end else begin
      sil[d] = 0;
      if (ck[d]) begin
        m_end(d, (int'(rx_byte) == xs[d]) ? 0 : 1);
      end else begin
        lane   = cnt[d] % bpe;
        acc[d] = ((lane == 0) ? 0 : acc[d]) + (int'(rx_byte) << (8 * lane));
        xs[d]  = xs[d] ^ int'(rx_byte);
        if (lane == bpe - 1) wq.push_back('{d, mat_m[d], cnt[d] / bpe, acc[d], cyc + 1});
        cnt[d]++;
        if (cnt[d] == NEL * bpe) begin
`ifdef UART_LOADER_CHECKSUM_EN
          ck[d] = 1'b1;
`else
          m_end(d, 0);
`endif
        end
      end
    end
    exp_bz[d] = inf[d];
  endfunction

  task automatic step(input bit v, input logic [7:0] b, input bit e);
    rx_valid = v; rx_byte = b; rx_err = e;
    model_step(0, 1);
    model_step(1, 2);
    @(negedge clk); #1;
    rx_valid = 1'b0; rx_err = 1'b0; clear_loaded = '0;
  endtask

  task automatic send(input logic [7:0] b);
    step(1'b1, b, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b0;
    wq.delete(); eq.delete();
    for (int d = 0; d < 2; d++) begin
      inf[d] = 1'b0; ck[d] = 1'b0; exp_bz[d] = 1'b0; exp_ld[d] = 0; sil[d] = 0; cnt[d] = 0;
    end
    for (int i = 0; i < n; i++) begin @(negedge clk); #1; end
    rst = 1'b1;
  endtask

  task automatic mon(input int d, input bit wen, input int wm, input int wa, input int wd,
                     input bit fd, input bit fe, input int ld, input bit bz);
    int i;
    if (!rst) begin
      chk(!wen && wm == 0 && wa == 0 && wd == 0 && !fd && !fe && ld == 0 && !bz,
          $sformatf("reset_state d%0d", d),
          $sformatf("got en %0b mat %0d addr %0d data %0h done %0b err %0b loaded %0d busy %0b, want all 0",
                    wen, wm, wa, wd, fd, fe, ld, bz));
      return;
    end
    i = wfind(d);
    if (wen || (i >= 0 && wq[i].cyc <= cyc)) begin
      chk(wen && i >= 0 && wq[i].cyc == cyc && wq[i].mat == wm && wq[i].addr == wa && wq[i].data == wd,
          $sformatf("write d%0d", d),
          $sformatf("cyc %0d got en %0b mat %0d addr %0d data %0h, want %s", cyc, wen, wm, wa, wd,
                    (i >= 0) ? $sformatf("write at cyc %0d mat %0d addr %0d data %0h",
                                         wq[i].cyc, wq[i].mat, wq[i].addr, wq[i].data) : "no write"));
      if (i >= 0) wq.delete(i);
    end
    i = efind(d);
    if (fd || fe || (i >= 0 && eq[i].cyc <= cyc)) begin
      chk(i >= 0 && eq[i].cyc == cyc && fd == (eq[i].kind == 0) && fe == (eq[i].kind == 1),
          $sformatf("pulse d%0d", d),
          $sformatf("cyc %0d got done %0b err %0b, want %s", cyc, fd, fe,
                    (i >= 0) ? $sformatf("%s at cyc %0d", (eq[i].kind == 0) ? "done" : "err", eq[i].cyc)
                             : "no pulse"));
      if (i >= 0) eq.delete(i);
    end
    chk(ld == exp_ld[d] && bz == exp_bz[d], $sformatf("status d%0d", d),
        $sformatf("cyc %0d got loaded %0d busy %0b, want loaded %0d busy %0b",
                  cyc, ld, bz, exp_ld[d], exp_bz[d]));
  endtask

  // Monitor: samples both loaders on the falling edge
  initial begin
    forever begin
      @(negedge clk);
      cyc = cyc + 1;
      mon(0, a_en, int'(a_mat), int'(a_addr), int'(a_data), a_fd, a_fe, int'(a_ld), a_bz);
      mon(1, b_en, int'(b_mat), int'(b_addr), int'(b_data), b_fd, b_fe, int'(b_ld), b_bz);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [7:0] h;
    rst = 1'b0; load_en = 1'b1; rx_valid = 1'b0; rx_err = 1'b0; rx_byte = '0; clear_loaded = '0;
    do_reset(3);

    // Basic 8-bit frame
    send(8'hA0); send(8'h11); send(8'h22); send(8'h33); send(8'h44); idle(3);
    do_reset(1);
    // 16-bit elements into matrix 1
    send(8'hA1); send(8'h34); send(8'h12); send(8'h78); send(8'h56);
    send(8'h9A); send(8'hBC); send(8'hF0); send(8'hDE); idle(3);
    do_reset(1);
    // Rejected headers
    send(8'hA7); send(8'h55); load_en = 1'b0; send(8'hA0); load_en = 1'b1; idle(3);
    // rx_err mid-frame, then a clean frame
    send(8'hA0); send(8'h11); send(8'h22); step(1'b1, 8'h33, 1'b1); idle(2);
    send(8'hA0); for (int k = 1; k <= 8; k++) send(8'(k)); idle(3);
    // Timeout, then reset mid-frame
    send(8'hA0); send(8'h11); idle(TMO + 5);
    send(8'hA0); send(8'h11); send(8'h22); send(8'h33); do_reset(2); idle(2);
    // clear_loaded coincident with set, load_en falling mid-frame
    send(8'hA0); send(8'h01); send(8'h02); send(8'h03); clear_loaded = 2'b01; send(8'h04); idle(2);
    clear_loaded = 2'b01; idle(2);
    send(8'hA1); send(8'h05); load_en = 1'b0; send(8'h06); send(8'h07); send(8'h08);
    send(8'h09); send(8'h0A); send(8'h0B); send(8'h0C); load_en = 1'b1; idle(3);
    do_reset(1);
    // Back-to-back frames
    send(8'hA0); send(8'h01); send(8'h02); send(8'h03); send(8'h04);
    send(8'hA1); send(8'h05); send(8'h06); send(8'h07); send(8'h08); idle(3);
    do_reset(1);
    // Checksum trailers (match, mismatch)
    send(8'hA0); send(8'h11); send(8'h22); send(8'h33); send(8'h44); send(8'h44); idle(2);
    send(8'hA0); send(8'h11); send(8'h22); send(8'h33); send(8'h44); send(8'h00); idle(2);
    do_reset(1);

    // Randomized traffic
    for (int f = 0; f < 150; f++) begin
      load_en = ($urandom_range(0, 7) != 0);
      n = $urandom_range(0, 9);
      if (n < 6)      h = {4'hA, 3'b000, 1'($urandom_range(0, 1))};
      else if (n < 8) h = {4'hA, 4'($urandom_range(2, 15))};
      else            h = 8'($urandom);
      send(h);
      n = $urandom_range(2, 10);
      for (int k = 0; k < n; k++) begin
        if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        if ($urandom_range(0, 39) == 0) idle(TMO + 2);
        if ($urandom_range(0, 19) == 0) clear_loaded = 2'($urandom);
        step(1'b1, 8'($urandom), ($urandom_range(0, 24) == 0));
      end
      if ($urandom_range(0, 49) == 0) do_reset(2);
    end
    load_en = 1'b1;
    idle(TMO + 5);

    chk(wq.size() == 0, "writes_outstanding", $sformatf("got %0d pending writes, want 0", wq.size()));
    chk(eq.size() == 0, "pulses_outstanding", $sformatf("got %0d pending pulses, want 0", eq.size()));
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
